// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer and the zestcore datapath.
// The master side is the controller: it reads instruction fields and
// datapath status, and drives enables, mux selects and the ALU operation.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_op, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_op, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the zestcore datapath (RV32I subset).
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready,
// and parks in a terminal trap state on unsupported encodings.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOP = 3'd5
  } alu_op_e;
endpackage

module multicycle_ctrl
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

  state_e  state;
  state_e  state_next;
  logic    load_q;
  alu_op_e dec_op;
  logic    dec_legal;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Remember lw vs sw at decode so MEMADR does not look at the IR fields.
  always_ff @(posedge clk) begin
    if (rst)                    load_q <= 1'b0;
    else if (state == S_DECODE) load_q <= (bus.opcode == OP_LW);
  end

  // ALU operation decode from funct3; SUB only exists for R-type execute.
  always_comb begin
    dec_op    = ALU_NOP;
    dec_legal = 1'b1;
    case (bus.funct3)
      3'b000:  dec_op = (state == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  dec_op = ALU_SLT;
      3'b110:  dec_op = ALU_OR;
      3'b111:  dec_op = ALU_AND;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and output decode; reset masks every enable and the ALU op.
  always_comb begin
    state_next     = state;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_NOP;
    bus.illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.alu_op     = ALU_ADD;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = dec_legal ? S_EXECR : S_TRAP;
          OP_I:         state_next = dec_legal ? S_EXECI : S_TRAP;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_ADD;
        state_next    = load_q ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = dec_op;
        state_next    = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = dec_op;
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = ALU_SUB;
        bus.pc_write  = bus.zero;
        state_next    = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = ALU_ADD;
        bus.pc_write  = 1'b1;
        state_next    = S_ALUWB;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
    if (rst) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.alu_op    = ALU_NOP;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the zestcore datapath, directly upstream of the ALU. It sequences each RV32I subset instruction through fetch, decode, execute, memory and writeback states. It drives the ALU operation (`alu_op_e` from `alu_pkg`), the datapath mux selects and the architectural write enables. It stalls on a memory ready handshake and traps on unsupported encodings.

## Interface
- No parameters; datapath width is fixed at 32 upstream.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU `y == 0`, combinational from the ALU this cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR and old-PC load enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALU-out register.
- `mem_write` out 1: data memory write request.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result select; 00 = ALU-out register, 01 = read data, 10 = live ALU `y`.
- `alu_src_a` out 2: ALU `a` select; 00 = PC, 01 = old PC, 10 = rs1 data.
- `alu_src_b` out 2: ALU `b` select; 00 = rs2 data, 01 = immediate, 10 = constant 4.
- `alu_op` out 3 (`alu_op_e`): encodings are ADD=0, SUB=1, AND=2, OR=3, SLT=4, NOP=5.
- `illegal` out 1: sticky trap flag.

## Operation
- Supported opcodes:
  - lw `0000011`, sw `0100011`.
  - R-type `0110011`, I-ALU `0010011`.
  - beq `1100011`, jal `1101111`.
- ALU decode for R-type and I-ALU, by `funct3`:
  - 000: ADD; SUB when R-type and `funct7b5` = 1.
  - 010: SLT.
  - 110: OR.
  - 111: AND.
  - Any other value: illegal.
- Output defaults: all enables 0, selects 00, `alu_op` NOP, `adr_src` 0. Each state below lists only the outputs that deviate from these defaults.
- FETCH: `alu_src_b`=10, `alu_op`=ADD, `result_src`=10. `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=ADD (precomputes the branch target). Next state by opcode:
  - lw/sw → MEMADR.
  - R-type → EXECR.
  - I-ALU → EXECI.
  - beq → BEQ.
  - jal → JAL.
  - Any other opcode → TRAP.
  - R-type or I-ALU with an illegal `funct3` → TRAP.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=ADD. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `adr_src`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Goes to FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=1, held steady until `mem_ready`. Then goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, decoded op. Goes to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, decoded op. `funct7b5` is ignored, so there is never a SUB. Goes to ALUWB.
- ALUWB: `reg_write`=1, `result_src`=00. Goes to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=SUB, `result_src`=00, `pc_write`=`zero`. Goes to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=ADD, `result_src`=00, `pc_write`=1. Goes to ALUWB, which writes the link address PC+4.
- TRAP: `illegal`=1 and all enables 0. Terminal state; only `rst` exits.
- Decode of `opcode`/`funct3`/`funct7b5` is sampled only in DECODE, EXECR and EXECI. The IR is stable in those states.

## Timing
- All outputs are Moore functions of state, except:
  - `pc_write`/`ir_write` in FETCH, which follow `mem_ready` combinationally.
  - `pc_write` in BEQ, which follows `zero` combinationally.
- `rst` sampled high forces the state to FETCH at the next edge.
- While `rst` is high, every enable output is forced to 0 and `alu_op` to NOP, regardless of state.
- After reset: `illegal`=0, and the FETCH outputs are active in the first cycle after `rst` falls.
- Reset mid-instruction (any state, including a MEMWRITE stall) aborts the instruction. No partial write enables are issued in the reset cycle.
- Latency with `mem_ready` always 1:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type / I-ALU: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle, and outputs stay constant during the stall.
- `mem_ready` is ignored in all other states.

## Test plan
- Reset then `add` (`0110011`, f3=000, f7b5=0), `mem_ready`=1:
  - Required sequence: FETCH, DECODE, EXECR (`alu_op`=ADD), ALUWB (`reg_write`=1), FETCH.
  - Repeat with f7b5=1: `alu_op`=SUB in EXECR.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - Total latency is 10 cycles.
  - `ir_write` pulses exactly once.
  - `reg_write` is asserted only in MEMWB, with `result_src`=01.
- sw with a 2-cycle MEMWRITE stall: `mem_write` stays high for exactly 3 consecutive cycles with `adr_src`=1, and `reg_write` is never asserted.
- beq with `zero`=1, then again with `zero`=0: `pc_write` is 1 and 0 respectively in the BEQ cycle, and the FSM returns to FETCH in both cases.
- I-ALU with f3=001, and separately opcode `1111111`:
  - TRAP is entered after DECODE and `illegal`=1.
  - All enables stay 0 for 20 cycles.
  - `rst` clears to FETCH with `illegal`=0.
- Assert `rst` during a MEMWRITE stall: `mem_write`=0 in the reset cycle, and the state is FETCH on the next edge.
